// File: rtl/result_byte_serializer_pkg.sv
// Shared types and byte-count helpers for the result byte serializer.
// Header and data words are sent as whole bytes, MSB byte first.
package result_byte_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_HEAD,
        S_SEND_DATA,
        S_DONE
    } state_e;

    localparam int CNT_W = 3;

    function automatic int nbytes(input int bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int nh_bytes(input int head_bits);
        return nbytes(head_bits);
    endfunction

    function automatic int nd_bytes(input int data_bits);
        return nbytes(data_bits);
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector against a registered copy of the input.
// The copy resets low, so a level already high at reset release fires once.
module edge_detect_rise (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = en_i & sig_i & ~sig_q;

endmodule

// File: rtl/result_byte_serializer.sv
// Captures a header/result pair on a DATA_VALID rising edge and streams
// it out as a valid/ready byte frame; extra triggers mid-frame are dropped.
module result_byte_serializer
    import result_byte_serializer_pkg::*;
#(
    parameter int BITWIDTH_DATA = 16,
    parameter int BITWIDTH_HEAD = 26
) (
    input  logic                     CLK_SYS,
    input  logic                     RSTN,
    input  logic                     EN,
    input  logic [BITWIDTH_DATA-1:0] DATA_IN,
    input  logic [BITWIDTH_HEAD-1:0] DATA_HEAD,
    input  logic                     DATA_VALID,
    input  logic                     TX_READY,
    output logic [7:0]               TX_DATA,
    output logic                     TX_VALID,
    output logic                     BUSY,
    output logic                     FRAME_DONE,
    output logic                     OVERFLOW
);

    localparam int NH = nh_bytes(BITWIDTH_HEAD);
    localparam int ND = nd_bytes(BITWIDTH_DATA);
    localparam int HW = NH * 8;
    localparam int DW = ND * 8;
    localparam logic [CNT_W-1:0] NH_LAST = CNT_W'(NH - 1);
    localparam logic [CNT_W-1:0] ND_LAST = CNT_W'(ND - 1);

    state_e           state_q;
    logic [HW-1:0]    head_q;
    logic [DW-1:0]    data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    logic          trig;
    logic          xfer;
    logic [HW-1:0] head_ext;
    logic [DW-1:0] data_ext;

    assign head_ext = HW'(DATA_HEAD);
    assign data_ext = DW'(DATA_IN);
    assign xfer     = tx_valid_q & TX_READY;

    edge_detect_rise u_edge (
        .clk_i  (CLK_SYS),
        .rst_ni (RSTN),
        .en_i   (EN),
        .sig_i  (DATA_VALID),
        .rise_o (trig)
    );

    // head_q/data_q shift left as bytes go out; the top byte is next.
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (!EN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (trig && state_q != S_IDLE) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        state_q    <= S_SEND_HEAD;
                        head_q     <= head_ext << 8;
                        data_q     <= data_ext;
                        tx_data_q  <= head_ext[HW-1 -: 8];
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                S_SEND_HEAD: begin
                    if (xfer) begin
                        if (cnt_q == NH_LAST) begin
                            state_q   <= S_SEND_DATA;
                            cnt_q     <= '0;
                            tx_data_q <= data_q[DW-1 -: 8];
                            data_q    <= data_q << 8;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            tx_data_q <= head_q[HW-1 -: 8];
                            head_q    <= head_q << 8;
                        end
                    end
                end
                S_SEND_DATA: begin
                    if (xfer) begin
                        if (cnt_q == ND_LAST) begin
                            state_q    <= S_DONE;
                            cnt_q      <= '0;
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            tx_data_q <= data_q[DW-1 -: 8];
                            data_q    <= data_q << 8;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TX_DATA    = tx_data_q;
    assign TX_VALID   = tx_valid_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: doc/result_byte_serializer.md
RESULT_BYTE_SERIALIZER -- requirements
Module: result_byte_serializer

Interface
REQ-001 Parameter BITWIDTH_DATA, default 16: result word width, legal range 8..31.
REQ-002 Parameter BITWIDTH_HEAD, default 26: skeleton metadata width, legal range 8..32.
REQ-003 CLK_SYS  input  1  system clock; all state changes on its rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 EN  input  1  block enable; low aborts and holds idle.
REQ-006 DATA_IN  input  BITWIDTH_DATA  result word from the upstream skeleton.
REQ-007 DATA_HEAD  input  BITWIDTH_HEAD  skeleton metadata word.
REQ-008 DATA_VALID  input  1  level-high while DATA_IN and DATA_HEAD are valid.
REQ-009 TX_READY  input  1  byte transmitter can accept a byte.
REQ-010 TX_DATA  output  8  byte offered to the transmitter.
REQ-011 TX_VALID  output  1  TX_DATA is valid.
REQ-012 BUSY  output  1  a frame is being sent.
REQ-013 FRAME_DONE  output  1  one-cycle pulse after the last byte of a frame is accepted.
REQ-014 OVERFLOW  output  1  sticky flag: a result was dropped.

Function
REQ-015 NH = ceil(BITWIDTH_HEAD/8) and ND = ceil(BITWIDTH_DATA/8); header and data are zero-extended on the MSB side to NH*8 and ND*8 bits.
REQ-016 Frame = NH header bytes followed by ND data bytes, each word sent MSB byte first.
REQ-017 Trigger = rising edge of DATA_VALID, detected against a registered copy of DATA_VALID, while EN=1.
REQ-018 FSM states: IDLE, SEND_HEAD, SEND_DATA, DONE.
REQ-019 IDLE with trigger at edge k: capture DATA_HEAD and DATA_IN into shadow registers, move to SEND_HEAD; TX_VALID=1 with the first header byte from cycle k+1.
REQ-020 Byte transfer occurs when TX_VALID=1 and TX_READY=1 at a rising edge; byte counter then advances.
REQ-021 While TX_VALID=1 and TX_READY=0, TX_DATA holds stable.
REQ-022 When the last header byte is accepted, go to SEND_DATA; TX_VALID stays high with no bubble.
REQ-023 When the last data byte is accepted, go to DONE; TX_VALID=0 in DONE; FRAME_DONE=1 for exactly that one cycle; next state IDLE.
REQ-024 BUSY=1 in SEND_HEAD, SEND_DATA and DONE.
REQ-025 Trigger while not IDLE: the frame in flight continues unchanged, the new result is dropped, OVERFLOW is set.
REQ-026 Trigger coincident with the DONE cycle also counts as an overflow.
REQ-027 EN=0 in any state: go to IDLE at the next edge, TX_VALID=0, counters cleared, OVERFLOW cleared; a partially sent frame is abandoned.
REQ-028 DATA_VALID held high continuously yields exactly one frame.
REQ-029 TX_READY is ignored while TX_VALID=0.

Reset
REQ-030 RSTN=0 asynchronously forces: state IDLE, TX_DATA=0x00, TX_VALID=0, BUSY=0, FRAME_DONE=0, OVERFLOW=0, shadow registers 0, byte counter 0, registered DATA_VALID=0.
REQ-031 After RSTN rises, a DATA_VALID already high counts as a rising edge on the first clock.

Structure
REQ-032 A shared package holds the FSM state encoding and the NH/ND byte-count derivation functions.
REQ-033 One sub-module, edge_detect_rise, produces the trigger pulse; everything else stays in result_byte_serializer.

Verification
REQ-034 Default parameters, TX_READY=1, DATA_HEAD=0x0010610, DATA_IN=0xBEEF, one DATA_VALID edge -> TX_DATA 0x00,0x01,0x06,0x10,0xBE,0xEF on 6 consecutive cycles, then a single FRAME_DONE pulse.
REQ-035 Same frame with TX_READY toggling 1-0-0-1 repeatedly -> identical byte sequence, TX_DATA stable during stalls, no byte lost or duplicated.
REQ-036 Second DATA_VALID edge (DATA_IN=0x1234) during the third header byte -> first frame completes with 0xBEEF, OVERFLOW=1, no 0x12/0x34 emitted.
REQ-037 EN driven low after 2 bytes accepted -> TX_VALID=0 and BUSY=0 next cycle, OVERFLOW=0; a new edge with EN=1 restarts at header byte 0x00.
REQ-038 RSTN pulsed low mid-frame, asynchronously between clock edges -> all outputs at reset values immediately; DATA_VALID high at release -> one new frame.
REQ-039 BITWIDTH_DATA=12, DATA_IN=0xABC -> data bytes 0x0A,0xBC.
